// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the memory port arbiter
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } arb_state_t;

    localparam logic [4:0]  STALL_ALL = 5'b11111;
    localparam logic [4:0]  STALL_PC  = 5'b00001;
    localparam logic [31:0] NOP_INSTR = 32'd0;

endpackage

// File: rtl/arb_timeout_ctr.sv
// rtl/arb_timeout_ctr.sv - 8-bit busy-cycle counter that flags when LIMIT is reached
module arb_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fires on the enabled cycle that would bring the count up to LIMIT.
    assign expired = en & ~clear & (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates IF and MEM stages onto one memory port and drives stalls
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [4:0]        stall,
    output logic              fetch_bubble,
    output logic              err
);

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              err_q, err_d;

    logic dm_wait, if_wait, tmo_expired, busy;

    // The served request is still asserted in its valid cycle; masking it stops a re-issue.
    assign dm_wait = dm_req & ~dm_valid_q;
    assign if_wait = if_req & ~if_valid_q;
    assign busy    = (state_q != IDLE);

    arb_timeout_ctr #(.LIMIT(TIMEOUT)) u_tmo (
        .clk    (Clk),
        .resetn (Rst),
        .clear  (~busy),
        .en     (busy & ~mem_ack),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (dm_wait) begin
                    state_d     = DM_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (if_wait) begin
                    state_d    = IF_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            DM_BUSY, IF_BUSY: begin
                if (mem_ack || tmo_expired) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == DM_BUSY) begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_ack ? mem_rdata : DATA_W'(NOP_INSTR);
                    end
                    if (!mem_ack) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall        = 5'b00000;
        fetch_bubble = 1'b0;
        if (dm_wait) begin
            stall = STALL_ALL;
        end else if (if_wait) begin
            stall        = STALL_PC;
            fetch_bubble = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [4:0]  stall;
    logic        fetch_bubble;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_valid    (dm_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall       (stall),
        .fetch_bubble(fetch_bubble),
        .err         (err)
    );

    // Advance one cycle; inputs set after this apply to the new cycle.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0; if_req = 1'b1; if_addr = 32'h0; mem_ack = 1'b1; mem_rdata = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        tick();
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req); end
        total++; if ({mem_we, mem_addr, mem_wdata} !== 65'd0) begin bad++; $display("FAIL rst_mem_bus got=%0h exp=0", {mem_we, mem_addr, mem_wdata}); end
        total++; if ({if_valid, dm_valid, err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%03b exp=000", {if_valid, dm_valid, err}); end
        total++; if ({if_rdata, dm_rdata} !== 64'd0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", {if_rdata, dm_rdata}); end
        Rst = 1'b1; mem_ack = 1'b0;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_release_fetch got req=%0b addr=%0h we=%0b exp req=1 addr=0 we=0", mem_req, mem_addr, mem_we); end
        mem_ack = 1'b1; mem_rdata = 32'h0;
        tick();
        mem_ack = 1'b0;
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL rst_first_fetch_valid got=%0b exp=1", if_valid); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h4; mem_rdata = 32'h2002000A;
        settle();
        total++; if (stall !== 5'b00001 || fetch_bubble !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL fetch_c0 got stall=%05b bub=%0b req=%0b exp 00001/1/0", stall, fetch_bubble, mem_req); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            mem_ack = (c == 3);
            settle();
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h4 || stall !== 5'b00001 || fetch_bubble !== 1'b1 || if_valid !== 1'b0) begin
                bad++;
                $display("FAIL fetch_c%0d got req=%0b addr=%0h stall=%05b bub=%0b vld=%0b exp 1/4/00001/1/0", c, mem_req, mem_addr, stall, fetch_bubble, if_valid);
            end
        end
        tick();
        mem_ack = 1'b0;
        settle();
        total++; if (if_valid !== 1'b1 || if_rdata !== 32'h2002000A) begin bad++; $display("FAIL fetch_valid got vld=%0b data=%0h exp 1/2002000a", if_valid, if_rdata); end
        total++; if (mem_req !== 1'b0 || stall !== 5'b00000 || fetch_bubble !== 1'b0) begin bad++; $display("FAIL fetch_c4_idle got req=%0b stall=%05b bub=%0b exp 0/00000/0", mem_req, stall, fetch_bubble); end
        tick();
        if_req = 1'b0;
        settle();
        total++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL fetch_no_reissue got vld=%0b req=%0b exp 0/0", if_valid, mem_req); end
    endtask

    task automatic test_priority();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10; if_req = 1'b1; if_addr = 32'h8;
        settle();
        total++; if (stall !== 5'b11111 || fetch_bubble !== 1'b0) begin bad++; $display("FAIL prio_c0 got stall=%05b bub=%0b exp 11111/0", stall, fetch_bubble); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        settle();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || stall !== 5'b11111) begin bad++; $display("FAIL prio_c1 got req=%0b addr=%0h we=%0b stall=%05b exp 1/10/0/11111", mem_req, mem_addr, mem_we, stall); end
        tick();
        mem_ack = 1'b0;
        settle();
        total++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h12345678) begin bad++; $display("FAIL prio_dm_valid got vld=%0b data=%0h exp 1/12345678", dm_valid, dm_rdata); end
        total++; if (mem_req !== 1'b0 || stall !== 5'b00001 || fetch_bubble !== 1'b1) begin bad++; $display("FAIL prio_c2 got req=%0b stall=%05b bub=%0b exp 0/00001/1", mem_req, stall, fetch_bubble); end
        tick();
        dm_req = 1'b0;
        settle();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || dm_valid !== 1'b0) begin bad++; $display("FAIL prio_fetch_c3 got req=%0b addr=%0h dvld=%0b exp 1/8/0", mem_req, mem_addr, dm_valid); end
        mem_ack = 1'b1; mem_rdata = 32'h8C220000;
        tick();
        mem_ack = 1'b0;
        settle();
        total++; if (if_valid !== 1'b1 || if_rdata !== 32'h8C220000) begin bad++; $display("FAIL prio_fetch_valid got vld=%0b data=%0h exp 1/8c220000", if_valid, if_rdata); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hCAFEF00D; mem_rdata = 32'h55AA55AA;
        tick();
        dm_addr = 32'hDEAD0000; dm_wdata = 32'h0BADBEEF;
        settle();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL store_c1 got req=%0b we=%0b addr=%0h data=%0h exp 1/1/20/cafef00d", mem_req, mem_we, mem_addr, mem_wdata); end
        tick();
        mem_ack = 1'b1;
        settle();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL store_stable got req=%0b we=%0b addr=%0h data=%0h exp 1/1/20/cafef00d", mem_req, mem_we, mem_addr, mem_wdata); end
        tick();
        mem_ack = 1'b0;
        settle();
        total++; if (dm_valid !== 1'b1 || mem_req !== 1'b0 || stall !== 5'b00000) begin bad++; $display("FAIL store_c3 got vld=%0b req=%0b stall=%05b exp 1/0/00000", dm_valid, mem_req, stall); end
        tick();
        dm_req = 1'b0; dm_we = 1'b0;
        settle();
        total++; if (mem_req !== 1'b0 || dm_valid !== 1'b0) begin bad++; $display("FAIL store_no_rewrite got req=%0b vld=%0b exp 0/0", mem_req, dm_valid); end
    endtask

    task automatic test_timeout();
        int held = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; mem_rdata = 32'hFFFFFFFF; mem_ack = 1'b0;
        for (int c = 1; c <= 255; c++) begin
            tick();
            if (mem_req === 1'b1) held++;
        end
        total++; if (held !== 255) begin bad++; $display("FAIL tmo_req_held got=%0d exp=255", held); end
        tick();
        total++; if (mem_req !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL tmo_abort got req=%0b err=%0b exp 0/1", mem_req, err); end
        total++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0) begin bad++; $display("FAIL tmo_valid got vld=%0b data=%0h exp 1/0", dm_valid, dm_rdata); end
        tick();
        dm_req = 1'b0;
        settle();
        total++; if (err !== 1'b1 || dm_valid !== 1'b0) begin bad++; $display("FAIL tmo_sticky got err=%0b vld=%0b exp 1/0", err, dm_valid); end
        if_req = 1'b1; if_addr = 32'hC;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'hC) begin bad++; $display("FAIL tmo_next_req got req=%0b addr=%0h exp 1/c", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h00000020;
        tick();
        mem_ack = 1'b0;
        settle();
        total++; if (if_valid !== 1'b1 || if_rdata !== 32'h20 || err !== 1'b1) begin bad++; $display("FAIL tmo_next_done got vld=%0b data=%0h err=%0b exp 1/20/1", if_valid, if_rdata, err); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_busy();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h50; mem_rdata = 32'h77777777;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h50) begin bad++; $display("FAIL rstb_busy got req=%0b addr=%0h exp 1/50", mem_req, mem_addr); end
        Rst = 1'b0; dm_req = 1'b0;
        tick();
        Rst = 1'b1;
        settle();
        total++; if (mem_req !== 1'b0 || stall !== 5'b00000 || err !== 1'b0) begin bad++; $display("FAIL rstb_dropped got req=%0b stall=%05b err=%0b exp 0/00000/0", mem_req, stall, err); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        settle();
        total++; if (dm_valid !== 1'b0 || if_valid !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h0) begin bad++; $display("FAIL rstb_late_ack got dvld=%0b ivld=%0b req=%0b data=%0h exp 0/0/0/0", dm_valid, if_valid, mem_req, dm_rdata); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_timeout();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
